// File: rtl/dmem_arbiter_if.sv
// Bundle shared by dmem_arbiter: both requester ports plus the data_mem side.
// slave = arbiter view; master = requesters and memory model.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_0;
    logic                  we_0;
    logic [2:0]            op_0;
    logic [ADDR_WIDTH-1:0] addr_0;
    logic [DATA_WIDTH-1:0] wdata_0;
    logic                  gnt_0;
    logic                  rsp_vld_0;
    logic                  rsp_err_0;
    logic [DATA_WIDTH-1:0] rdata_0;

    logic                  req_1;
    logic                  we_1;
    logic [2:0]            op_1;
    logic [ADDR_WIDTH-1:0] addr_1;
    logic [DATA_WIDTH-1:0] wdata_1;
    logic                  gnt_1;
    logic                  rsp_vld_1;
    logic                  rsp_err_1;
    logic [DATA_WIDTH-1:0] rdata_1;

    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [2:0]            mem_op;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_wr;
    logic [DATA_WIDTH-1:0] mem_data_rd;

    modport slave (
        input  req_0, we_0, op_0, addr_0, wdata_0,
        input  req_1, we_1, op_1, addr_1, wdata_1,
        input  mem_data_rd,
        output gnt_0, rsp_vld_0, rsp_err_0, rdata_0,
        output gnt_1, rsp_vld_1, rsp_err_1, rdata_1,
        output mem_wr_en, mem_rd_en, mem_op, mem_addr, mem_data_wr
    );

    modport master (
        output req_0, we_0, op_0, addr_0, wdata_0,
        output req_1, we_1, op_1, addr_1, wdata_1,
        output mem_data_rd,
        input  gnt_0, rsp_vld_0, rsp_err_0, rdata_0,
        input  gnt_1, rsp_vld_1, rsp_err_1, rdata_1,
        input  mem_wr_en, mem_rd_en, mem_op, mem_addr, mem_data_wr
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of data_mem.
// One access per grant, screened for alignment/op legality, fixed 2-cycle response.
//
//   state  | meaning
//   IDLE   | no access in flight, arbitrate
//   ACCESS | memory strobe cycle for the latched request
//   RESP   | response cycle, arbitrate for the next access
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus_io
);
    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LH  = 3'd1;
    localparam logic [2:0] MEM_LW  = 3'd2;
    localparam logic [2:0] MEM_LBU = 3'd3;
    localparam logic [2:0] MEM_LHU = 3'd4;
    localparam logic [2:0] MEM_SB  = 3'd5;
    localparam logic [2:0] MEM_SH  = 3'd6;
    localparam logic [2:0] MEM_SW  = 3'd7;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  port_q, port_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            rsp_vld_q, rsp_vld_d;
    logic [1:0]            rsp_err_q, rsp_err_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [2:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [1:0]            req;
    logic                  win_vld;
    logic                  win;
    logic                  sel_we;
    logic [2:0]            sel_op;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  op_ok;
    logic                  legal;
    logic                  rd_pass;

    assign req     = {bus_io.req_1, bus_io.req_0};
    assign win_vld = |req;
    // On a tie the port that did not win last time goes first.
    assign win     = (req == 2'b11) ? ~last_q : req[1];

    assign sel_we    = win ? bus_io.we_1    : bus_io.we_0;
    assign sel_op    = win ? bus_io.op_1    : bus_io.op_0;
    assign sel_addr  = win ? bus_io.addr_1  : bus_io.addr_0;
    assign sel_wdata = win ? bus_io.wdata_1 : bus_io.wdata_0;

    always_comb begin
        op_ok = 1'b0;
        if (sel_we) begin
            case (sel_op)
                MEM_SB, MEM_SH, MEM_SW: op_ok = 1'b1;
                default:                op_ok = 1'b0;
            endcase
        end else begin
            case (sel_op)
                MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: op_ok = 1'b1;
                default:                                  op_ok = 1'b0;
            endcase
        end
    end

    assign legal = op_ok && (sel_addr[1:0] == 2'b00);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        port_d    = port_q;
        we_d      = we_q;
        err_d     = err_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gnt_d     = 2'b00;
        rsp_vld_d = 2'b00;
        rsp_err_d = 2'b00;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (win_vld) begin
                    state_d    = ACCESS;
                    last_d     = win;
                    port_d     = win;
                    we_d       = sel_we;
                    err_d      = ~legal;
                    op_d       = sel_op;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    gnt_d[win] = 1'b1;
                    wr_en_d    = legal & sel_we;
                    rd_en_d    = legal & ~sel_we;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d           = RESP;
                rsp_vld_d[port_q] = 1'b1;
                rsp_err_d[port_q] = err_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            gnt_q     <= 2'b00;
            rsp_vld_q <= 2'b00;
            rsp_err_q <= 2'b00;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            port_q    <= port_d;
            we_q      <= we_d;
            err_q     <= err_d;
            gnt_q     <= gnt_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_err_q <= rsp_err_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Load data comes straight from the memory's output register, gated to the served port.
    assign rd_pass = (state_q == RESP) && !we_q && !err_q;

    assign bus_io.gnt_0       = gnt_q[0];
    assign bus_io.gnt_1       = gnt_q[1];
    assign bus_io.rsp_vld_0   = rsp_vld_q[0];
    assign bus_io.rsp_vld_1   = rsp_vld_q[1];
    assign bus_io.rsp_err_0   = rsp_err_q[0];
    assign bus_io.rsp_err_1   = rsp_err_q[1];
    assign bus_io.rdata_0     = (rd_pass && !port_q) ? bus_io.mem_data_rd : '0;
    assign bus_io.rdata_1     = (rd_pass &&  port_q) ? bus_io.mem_data_rd : '0;
    assign bus_io.mem_wr_en   = wr_en_q;
    assign bus_io.mem_rd_en   = rd_en_q;
    assign bus_io.mem_op      = op_q;
    assign bus_io.mem_addr    = addr_q;
    assign bus_io.mem_data_wr = wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small registered data_mem model.
module tb_dmem_arbiter;
    localparam logic [2:0] MEM_LW = 3'd2;
    localparam logic [2:0] MEM_SB = 3'd5;
    localparam logic [2:0] MEM_SW = 3'd7;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:63] = '{1: 32'h0404_0404, default: 32'h0};

    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr[7:2]] <= bus.mem_data_wr;
        if (bus.mem_rd_en) bus.mem_data_rd <= mem[bus.mem_addr[7:2]];
    end

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input bit r, input bit we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 1'b0) begin
            bus.req_0 = r; bus.we_0 = we; bus.op_0 = op; bus.addr_0 = addr; bus.wdata_0 = wdata;
        end else begin
            bus.req_1 = r; bus.we_1 = we; bus.op_1 = op; bus.addr_1 = addr; bus.wdata_1 = wdata;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.mem_data_rd = '0;
        drive(0, 0, 0, MEM_LW, 32'h0, 32'h0);
        drive(1, 0, 0, MEM_LW, 32'h0, 32'h0);
        step();
        step();
        chk_val("rst_gnt",   {bus.gnt_1, bus.gnt_0}, 2'b00);
        chk_val("rst_strb",  {bus.mem_wr_en, bus.mem_rd_en}, 2'b00);
        chk_val("rst_addr",  bus.mem_addr, 32'h0);
        chk_val("rst_vld",   {bus.rsp_vld_1, bus.rsp_vld_0}, 2'b00);
        rst = 1'b0;

        // store then load on port 0
        drive(0, 1, 1, MEM_SW, 32'h10, 32'hDEAD_BEEF);
        step();
        chk_val("st_gnt0",   bus.gnt_0, 1'b1);
        chk_val("st_wr_en",  bus.mem_wr_en, 1'b1);
        chk_val("st_addr",   bus.mem_addr, 32'h10);
        chk_val("st_wdata",  bus.mem_data_wr, 32'hDEAD_BEEF);
        drive(0, 0, 0, MEM_LW, 32'h0, 32'h0);
        step();
        chk_val("st_vld0",   {bus.rsp_vld_0, bus.rsp_err_0}, 2'b10);
        chk_val("st_rdata0", bus.rdata_0, 32'h0);
        step();
        drive(0, 1, 0, MEM_LW, 32'h10, 32'h0);
        step();
        chk_val("ld_gnt0",   bus.gnt_0, 1'b1);
        chk_val("ld_strb",   {bus.mem_wr_en, bus.mem_rd_en}, 2'b01);
        chk_val("ld_addr",   bus.mem_addr, 32'h10);
        drive(0, 0, 0, MEM_LW, 32'h0, 32'h0);
        step();
        chk_val("ld_vld0",   {bus.rsp_vld_0, bus.rsp_err_0}, 2'b10);
        chk_val("ld_rdata0", bus.rdata_0, 32'hDEAD_BEEF);
        chk_val("ld_other",  {bus.rsp_vld_1, bus.rdata_1}, 33'h0);
        step();

        // misaligned store on port 1
        drive(1, 1, 1, MEM_SW, 32'h13, 32'h1234_5678);
        step();
        chk_val("mis_gnt1",  {bus.gnt_1, bus.gnt_0}, 2'b10);
        chk_val("mis_strb",  {bus.mem_wr_en, bus.mem_rd_en}, 2'b00);
        drive(1, 0, 0, MEM_LW, 32'h0, 32'h0);
        step();
        chk_val("mis_rsp1",  {bus.rsp_vld_1, bus.rsp_err_1}, 2'b11);
        chk_val("mis_rdata", bus.rdata_1, 32'h0);
        step();
        drive(1, 1, 0, MEM_LW, 32'h10, 32'h0);
        step();
        drive(1, 0, 0, MEM_LW, 32'h0, 32'h0);
        step();
        chk_val("mis_reld",  bus.rdata_1, 32'hDEAD_BEEF);
        step();

        // load using a store op code
        drive(0, 1, 0, MEM_SB, 32'h10, 32'h0);
        step();
        chk_val("ill_gnt0",  bus.gnt_0, 1'b1);
        chk_val("ill_strb",  {bus.mem_wr_en, bus.mem_rd_en}, 2'b00);
        drive(0, 0, 0, MEM_LW, 32'h0, 32'h0);
        step();
        chk_val("ill_rsp0",  {bus.rsp_vld_0, bus.rsp_err_0}, 2'b11);
        chk_val("ill_rdata", bus.rdata_0, 32'h0);
        step();

        // back-to-back on port 0 with request held through the grant
        drive(0, 1, 0, MEM_LW, 32'h10, 32'h0);
        step();
        chk_val("b2b_g1",    bus.gnt_0, 1'b1);
        step();
        chk_val("b2b_r1",    {bus.gnt_0, bus.rsp_vld_0}, 2'b01);
        chk_val("b2b_d1",    bus.rdata_0, 32'hDEAD_BEEF);
        step();
        chk_val("b2b_g2",    {bus.gnt_0, bus.rsp_vld_0}, 2'b10);
        drive(0, 1, 0, MEM_LW, 32'h10, 32'h0);
        step();
        chk_val("b2b_r2",    {bus.gnt_0, bus.rsp_vld_0}, 2'b01);
        drive(0, 0, 0, MEM_LW, 32'h0, 32'h0);
        step();
        chk_val("b2b_idle",  {bus.gnt_0, bus.mem_rd_en}, 2'b00);

        // reset in the middle of a store
        drive(0, 1, 1, MEM_SW, 32'h20, 32'hAAAA_5555);
        step();
        chk_val("rma_wr_en", bus.mem_wr_en, 1'b1);
        rst = 1'b1;
        #1;
        chk_val("rma_gnt",   {bus.gnt_1, bus.gnt_0}, 2'b00);
        chk_val("rma_strb",  {bus.mem_wr_en, bus.mem_rd_en}, 2'b00);
        chk_val("rma_op",    bus.mem_op, 3'd0);
        chk_val("rma_addr",  bus.mem_addr, 32'h0);
        chk_val("rma_wdata", bus.mem_data_wr, 32'h0);
        drive(0, 0, 0, MEM_LW, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk_val("rma_vld_a", {bus.rsp_vld_1, bus.rsp_vld_0}, 2'b00);
        step();
        chk_val("rma_vld_b", {bus.rsp_vld_1, bus.rsp_vld_0}, 2'b00);
        chk_val("rma_mem",   mem[8], 32'h0);

        // both ports contend every cycle; port 0 wins the first tie after reset
        drive(0, 1, 0, MEM_LW, 32'h0, 32'h0);
        drive(1, 1, 0, MEM_LW, 32'h4, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            int p;
            p = ((k - 1) / 2) % 2;
            step();
            if (k % 2 == 1) begin
                chk_val($sformatf("rr_gnt_%0d", k), {bus.gnt_1, bus.gnt_0}, (p == 0) ? 2'b01 : 2'b10);
                chk_val($sformatf("rr_strb_%0d", k), {bus.mem_wr_en, bus.mem_rd_en}, 2'b01);
            end else begin
                chk_val($sformatf("rr_vld_%0d", k), {bus.rsp_vld_1, bus.rsp_vld_0}, (p == 0) ? 2'b01 : 2'b10);
                chk_val($sformatf("rr_strb_%0d", k), {bus.mem_wr_en, bus.mem_rd_en}, 2'b00);
                chk_val($sformatf("rr_data_%0d", k), (p == 0) ? bus.rdata_0 : bus.rdata_1,
                        (p == 0) ? 32'h0 : 32'h0404_0404);
            end
        end
        drive(0, 0, 0, MEM_LW, 32'h0, 32'h0);
        drive(1, 0, 0, MEM_LW, 32'h0, 32'h0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
